// File: rtl/eth_stats_counter_bank_if.sv
// -----------------------------------------------------------------------------
// eth_stats_counter_bank_if
//   Snapshot output stream of eth_stats_counter_bank: one channel per beat.
//
//   Handshake: a beat transfers on a rising clk edge where out_valid and
//   out_ready are both 1. While out_valid=1 and out_ready=0 every out_* field
//   stays stable. out_valid never drops without a transfer, except on reset.
//
//   Signals
//     out_valid    master->slave  beat valid
//     out_ready    slave->master  consumer accepts beat
//     out_channel  master->slave  channel index of the beat
//     out_time     master->slave  timestamp captured at snapshot request
//     out_bytes    master->slave  byte counter snapshot
//     out_good     master->slave  good frame counter snapshot
//     out_bad      master->slave  bad frame counter snapshot
//     out_last     master->slave  beat carries the last channel
// -----------------------------------------------------------------------------
interface eth_stats_counter_bank_if #(
   parameter int C_NUM_PORTS     = 4,
   parameter int C_COUNTER_WIDTH = 64
);
   localparam int CW = (C_NUM_PORTS > 1) ? $clog2(C_NUM_PORTS) : 1;

   logic                       out_valid;
   logic                       out_ready;
   logic [CW-1:0]              out_channel;
   logic [63:0]                out_time;
   logic [C_COUNTER_WIDTH-1:0] out_bytes;
   logic [C_COUNTER_WIDTH-1:0] out_good;
   logic [C_COUNTER_WIDTH-1:0] out_bad;
   logic                       out_last;

   modport master (
      output out_valid, out_channel, out_time, out_bytes, out_good, out_bad, out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_channel, out_time, out_bytes, out_good, out_bad, out_last,
      output out_ready
   );
endinterface

// File: rtl/eth_stats_counter_bank.sv
// -----------------------------------------------------------------------------
// eth_stats_counter_bank
//   Per-channel bytes / good-frame / bad-frame accumulators for C_NUM_PORTS
//   ethernet ports, with atomic timestamped snapshots streamed out one channel
//   per beat.
//
//   Compile-time option: define ETH_STATS_SATURATE_EN to make every counter
//   saturate at all-ones instead of wrapping modulo 2^W.
//
//   Ports
//     clk              single clock
//     rst              synchronous reset, active-high
//     enable           global accumulate enable
//     clear            per-channel counter clear (wins over in_valid)
//     current_time     reference timer, captured at snapshot
//     in_valid         per-channel completed-frame strobe
//     in_frame_length  per-channel frame byte count, channel i at [i*L +: L]
//     in_frame_good    per-channel 1 = good frame, 0 = bad frame
//     snap_req         snapshot request (ignored while streaming)
//     snap_busy        snapshot being streamed; this is the FSM state (SEND)
//     out_if           snapshot stream (master side)
// -----------------------------------------------------------------------------
module eth_stats_counter_bank #(
   parameter int C_NUM_PORTS     = 4,
   parameter int C_COUNTER_WIDTH = 64,
   parameter int C_LENGTH_WIDTH  = 16
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  enable,
   input  logic [C_NUM_PORTS-1:0]                clear,
   input  logic [63:0]                           current_time,
   input  logic [C_NUM_PORTS-1:0]                in_valid,
   input  logic [C_NUM_PORTS*C_LENGTH_WIDTH-1:0] in_frame_length,
   input  logic [C_NUM_PORTS-1:0]                in_frame_good,
   input  logic                                  snap_req,
   output logic                                  snap_busy,
   eth_stats_counter_bank_if.master              out_if
);
   localparam int W  = C_COUNTER_WIDTH;
   localparam int WX = C_COUNTER_WIDTH + 1;
   localparam int CW = (C_NUM_PORTS > 1) ? $clog2(C_NUM_PORTS) : 1;
   localparam logic [CW-1:0] LAST_CH = CW'(C_NUM_PORTS - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t         state;
   logic [W-1:0]   acc_bytes [C_NUM_PORTS];
   logic [W-1:0]   acc_good  [C_NUM_PORTS];
   logic [W-1:0]   acc_bad   [C_NUM_PORTS];
   logic [W-1:0]   shd_bytes [C_NUM_PORTS];
   logic [W-1:0]   shd_good  [C_NUM_PORTS];
   logic [W-1:0]   shd_bad   [C_NUM_PORTS];
   logic           valid_r;
   logic           last_r;
   logic [CW-1:0]  chan_r;
   logic [63:0]    time_r;

   // One extra bit of headroom exposes the carry so saturation can clamp.
   function automatic logic [W-1:0] acc_add(input logic [W-1:0] a, input logic [WX-1:0] b);
      logic [WX-1:0] s;
      s = {1'b0, a} + b;
`ifdef ETH_STATS_SATURATE_EN
      if (s[W]) s = {1'b0, {W{1'b1}}};
`endif
      return s[W-1:0];
   endfunction

   // Accumulators: every channel updates independently each cycle.
   always_ff @(posedge clk) begin
      for (int i = 0; i < C_NUM_PORTS; i++) begin
         if (rst || clear[i]) begin
            acc_bytes[i] <= '0;
            acc_good[i]  <= '0;
            acc_bad[i]   <= '0;
         end else if (enable && in_valid[i]) begin
            acc_bytes[i] <= acc_add(acc_bytes[i], WX'(in_frame_length[i*C_LENGTH_WIDTH +: C_LENGTH_WIDTH]));
            if (in_frame_good[i]) acc_good[i] <= acc_add(acc_good[i], WX'(1));
            else                  acc_bad[i]  <= acc_add(acc_bad[i], WX'(1));
         end
      end
   end

   // Snapshot FSM. Shadows take the registered counters at the request edge,
   // so a same-cycle frame or clear lands only in the live counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         valid_r <= 1'b0;
         last_r  <= 1'b0;
         chan_r  <= '0;
         time_r  <= '0;
         for (int i = 0; i < C_NUM_PORTS; i++) begin
            shd_bytes[i] <= '0;
            shd_good[i]  <= '0;
            shd_bad[i]   <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (snap_req) begin
                  for (int i = 0; i < C_NUM_PORTS; i++) begin
                     shd_bytes[i] <= acc_bytes[i];
                     shd_good[i]  <= acc_good[i];
                     shd_bad[i]   <= acc_bad[i];
                  end
                  time_r  <= current_time;
                  state   <= SEND;
                  valid_r <= 1'b1;
                  chan_r  <= '0;
                  last_r  <= (C_NUM_PORTS == 1);
               end
            end
            SEND: begin
               // snap_req is deliberately not looked at here: no queuing.
               if (valid_r && out_if.out_ready) begin
                  if (last_r) begin
                     state   <= IDLE;
                     valid_r <= 1'b0;
                     last_r  <= 1'b0;
                     chan_r  <= '0;
                  end else begin
                     chan_r <= chan_r + CW'(1);
                     last_r <= ((chan_r + CW'(1)) == LAST_CH);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign snap_busy          = (state == SEND);
   assign out_if.out_valid   = valid_r;
   assign out_if.out_last    = last_r;
   assign out_if.out_channel = chan_r;
   assign out_if.out_time    = time_r;
   // Shadows and channel are registered, so the beat is stable under stall.
   assign out_if.out_bytes   = shd_bytes[chan_r];
   assign out_if.out_good    = shd_good[chan_r];
   assign out_if.out_bad     = shd_bad[chan_r];
endmodule

// File: tb/tb_eth_stats_counter_bank.sv
// -----------------------------------------------------------------------------
// tb_eth_stats_counter_bank
//   Bench for eth_stats_counter_bank with 4 channels, 16-bit counters and
//   16-bit lengths. A reference model of the counters and the snapshot
//   acceptance rule pushes expected beats into exp_q; a monitor pops and
//   compares every accepted beat. A vector table drives the accumulation
//   cases, hand-written sequences cover stall, back-to-back and reset abort.
//   Honours ETH_STATS_SATURATE_EN for the overflow expectation.
// -----------------------------------------------------------------------------
module tb_eth_stats_counter_bank;
   localparam int N  = 4;
   localparam int W  = 16;
   localparam int L  = 16;
   localparam int CW = 2;
   localparam int BW = CW + 64 + 3 * W + 1;

`ifdef ETH_STATS_SATURATE_EN
   localparam logic [W-1:0] EXP_CH1_BYTES = 16'hFFFF;
`else
   localparam logic [W-1:0] EXP_CH1_BYTES = 16'd10;
`endif

   typedef struct packed {
      logic [CW-1:0] ch;
      logic [63:0]   tm;
      logic [W-1:0]  bytes;
      logic [W-1:0]  good;
      logic [W-1:0]  bad;
      logic          last;
   } beat_t;

   typedef struct packed {
      logic          en;
      logic [N-1:0]  clr;
      logic [N-1:0]  vld;
      logic [N-1:0]  good;
      logic [N*L-1:0] len;
      logic          snap;
      logic [CW-1:0] chk_ch;
      logic [W-1:0]  eb;
      logic [W-1:0]  eg;
      logic [W-1:0]  ebad;
   } vec_t;

   // clock/reset and DUT signals
   logic           clk = 1'b0;
   logic           rst;
   logic           enable;
   logic [N-1:0]   clear;
   logic [63:0]    current_time;
   logic [N-1:0]   in_valid;
   logic [N*L-1:0] in_frame_length;
   logic [N-1:0]   in_frame_good;
   logic           snap_req;
   logic           snap_busy;

   eth_stats_counter_bank_if #(.C_NUM_PORTS(N), .C_COUNTER_WIDTH(W)) out_if ();

   eth_stats_counter_bank #(
      .C_NUM_PORTS(N), .C_COUNTER_WIDTH(W), .C_LENGTH_WIDTH(L)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear),
      .current_time(current_time), .in_valid(in_valid),
      .in_frame_length(in_frame_length), .in_frame_good(in_frame_good),
      .snap_req(snap_req), .snap_busy(snap_busy), .out_if(out_if)
   );

   always #5 clk = ~clk;

   // scoreboard and model state
   logic [BW-1:0] exp_q[$];
   beat_t         got_q[$];
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   logic [W-1:0]  m_bytes [N];
   logic [W-1:0]  m_good  [N];
   logic [W-1:0]  m_bad   [N];
   bit            m_busy = 0;
   bit            m_end_pending = 0;
   beat_t         held;
   bit            held_v = 0;
   vec_t          vecs [11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_beat(input string name, input beat_t act, input beat_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got ch=%0d t=%h b=%0d g=%0d x=%0d l=%0d expected ch=%0d t=%h b=%0d g=%0d x=%0d l=%0d",
                  name, act.ch, act.tm, act.bytes, act.good, act.bad, act.last,
                  exp.ch, exp.tm, exp.bytes, exp.good, exp.bad, exp.last);
      end
   endtask

   function automatic logic [W-1:0] m_add(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b};
`ifdef ETH_STATS_SATURATE_EN
      if (s[W]) s = {1'b0, {W{1'b1}}};
`endif
      return s[W-1:0];
   endfunction

   function automatic vec_t mkv(input logic en, input logic [N-1:0] clr, input logic [N-1:0] vld,
                                input logic [N-1:0] good, input logic [L-1:0] l0, input logic [L-1:0] l1,
                                input logic [L-1:0] l2, input logic [L-1:0] l3, input logic snap,
                                input logic [CW-1:0] ch, input logic [W-1:0] eb, input logic [W-1:0] eg,
                                input logic [W-1:0] ebad);
      vec_t v;
      v.en = en; v.clr = clr; v.vld = vld; v.good = good;
      v.len = {l3, l2, l1, l0};
      v.snap = snap; v.chk_ch = ch; v.eb = eb; v.eg = eg; v.ebad = ebad;
      return v;
   endfunction

   // One clock: the model follows the inputs seen at the edge, then the
   // inputs may change 1 time unit later.
   task automatic step();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_bytes[i] = '0; m_good[i] = '0; m_bad[i] = '0;
         end
         m_busy = 0;
         m_end_pending = 0;
         exp_q.delete();
      end else begin
         if (!m_busy && snap_req) begin
            for (int i = 0; i < N; i++) begin
               beat_t b;
               b.ch = CW'(i); b.tm = current_time;
               b.bytes = m_bytes[i]; b.good = m_good[i]; b.bad = m_bad[i];
               b.last = (i == N - 1);
               exp_q.push_back(b);
            end
            m_busy = 1;
         end
         if (m_end_pending) begin
            m_busy = 0;
            m_end_pending = 0;
         end
         for (int i = 0; i < N; i++) begin
            if (clear[i]) begin
               m_bytes[i] = '0; m_good[i] = '0; m_bad[i] = '0;
            end else if (enable && in_valid[i]) begin
               m_bytes[i] = m_add(m_bytes[i], in_frame_length[i*L +: L]);
               if (in_frame_good[i]) m_good[i] = m_add(m_good[i], 1);
               else                  m_bad[i]  = m_add(m_bad[i], 1);
            end
         end
      end
      #1;
      cyc++;
      current_time = {32'hC0DE_0000, 32'(cyc)};
   endtask

   task automatic idle_inputs();
      enable = 1'b1; clear = '0; in_valid = '0; in_frame_good = '0;
      in_frame_length = '0; snap_req = 1'b0;
   endtask

   task automatic set_frame(input int ch, input int len, input bit good);
      in_valid[ch] = 1'b1;
      in_frame_length[ch*L +: L] = L'(len);
      in_frame_good[ch] = good;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((m_busy || exp_q.size() != 0) && n < 200) begin
         step();
         n++;
      end
      chk("stream_done", (n < 200), 1);
      chk("busy_after_stream", snap_busy, 0);
      chk("valid_after_stream", out_if.out_valid, 0);
   endtask

   task automatic chk_got(input string name, input int idx, input logic [W-1:0] eb,
                          input logic [W-1:0] eg, input logic [W-1:0] ebad);
      if (idx >= got_q.size()) begin
         chk({name, "_present"}, got_q.size(), idx + 1);
      end else begin
         chk({name, "_ch"}, got_q[idx].ch, idx);
         chk({name, "_bytes"}, got_q[idx].bytes, eb);
         chk({name, "_good"}, got_q[idx].good, eg);
         chk({name, "_bad"}, got_q[idx].bad, ebad);
      end
   endtask

   // Monitor: mid-cycle sampling of the stream; checks hold-under-stall and
   // compares each accepted beat against the scoreboard.
   always @(negedge clk) begin
      beat_t cur;
      beat_t e;
      if (rst) begin
         held_v = 0;
      end else if (out_if.out_valid === 1'b1) begin
         cur.ch = out_if.out_channel; cur.tm = out_if.out_time;
         cur.bytes = out_if.out_bytes; cur.good = out_if.out_good;
         cur.bad = out_if.out_bad; cur.last = out_if.out_last;
         if (held_v) chk_beat("stall_hold", cur, held);
         if (out_if.out_ready) begin
            held_v = 0;
            got_q.push_back(cur);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat: got ch=%0d with no beat expected", cur.ch);
            end else begin
               e = beat_t'(exp_q.pop_front());
               chk_beat("beat", cur, e);
               if (e.last) m_end_pending = 1;
            end
         end else begin
            held = cur;
            held_v = 1;
         end
      end else begin
         held_v = 0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      idle_inputs();
      out_if.out_ready = 1'b1;
      current_time = 64'h0;
      repeat (3) step();
      rst = 1'b0;

      // reset state
      chk("rst_busy", snap_busy, 0);
      chk("rst_valid", out_if.out_valid, 0);
      chk("rst_last", out_if.out_last, 0);
      chk("rst_channel", out_if.out_channel, 0);
      chk("rst_time", out_if.out_time, 0);

      // accumulation vectors
      vecs[0]  = mkv(1, 4'b0000, 4'b0001, 4'b0001, 64, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[1]  = mkv(1, 4'b0000, 4'b0001, 4'b0001, 1518, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[2]  = mkv(1, 4'b0000, 4'b0001, 4'b0000, 60, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[3]  = mkv(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 0, 1642, 2, 1);
      vecs[4]  = mkv(1, 4'b0000, 4'b1110, 4'b0110, 0, 65530, 100, 7, 0, 0, 0, 0, 0);
      vecs[5]  = mkv(0, 4'b0000, 4'b0010, 4'b0010, 0, 999, 0, 0, 0, 0, 0, 0, 0);
      vecs[6]  = mkv(1, 4'b0000, 4'b0010, 4'b0010, 0, 16, 0, 0, 0, 0, 0, 0, 0);
      vecs[7]  = mkv(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 1, EXP_CH1_BYTES, 2, 0);
      vecs[8]  = mkv(1, 4'b0100, 4'b1100, 4'b1100, 0, 0, 100, 40, 0, 0, 0, 0, 0);
      vecs[9]  = mkv(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 2, 0, 0, 0);
      vecs[10] = mkv(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 3, 47, 1, 1);

      for (int r = 0; r < 11; r++) begin
         enable = vecs[r].en; clear = vecs[r].clr; in_valid = vecs[r].vld;
         in_frame_good = vecs[r].good; in_frame_length = vecs[r].len;
         snap_req = vecs[r].snap;
         if (vecs[r].snap) got_q.delete();
         step();
         idle_inputs();
         if (vecs[r].snap) begin
            wait_idle();
            chk("row_beat_count", got_q.size(), N);
            chk_got($sformatf("row%0d", r), int'(vecs[r].chk_ch), vecs[r].eb, vecs[r].eg, vecs[r].ebad);
         end
      end

      // snapshot in the same cycle as a frame: snapshot sees old value
      clear = 4'b0001; step(); idle_inputs();
      set_frame(0, 100, 1); step(); idle_inputs();
      got_q.delete();
      set_frame(0, 64, 1); snap_req = 1'b1; step(); idle_inputs();
      wait_idle();
      chk_got("same_cycle_snap", 0, 100, 1, 0);
      got_q.delete();
      snap_req = 1'b1; step(); idle_inputs();
      wait_idle();
      chk_got("live_after_snap", 0, 164, 2, 0);

      // stall on beat 1 with traffic and ignored requests
      got_q.delete();
      out_if.out_ready = 1'b0;
      snap_req = 1'b1; step(); snap_req = 1'b0;
      out_if.out_ready = 1'b1; step();
      out_if.out_ready = 1'b0;
      chk("stall_channel", out_if.out_channel, 1);
      for (int k = 0; k < 5; k++) begin
         set_frame(1, 200 + k, k[0]);
         set_frame(3, 30, 1);
         snap_req = k[0];
         step();
         idle_inputs();
      end
      out_if.out_ready = 1'b1;
      wait_idle();
      chk("stall_beat_count", got_q.size(), N);

      // back-to-back: held request restarts after one idle cycle
      got_q.delete();
      snap_req = 1'b1;
      repeat (6) step();
      snap_req = 1'b0;
      wait_idle();
      chk("b2b_beat_count", got_q.size(), 2 * N);
      if (got_q.size() == 2 * N) chk("b2b_time_gap", got_q[N].tm - got_q[0].tm, 5);

      // reset while beat 2 is presented
      got_q.delete();
      out_if.out_ready = 1'b0;
      snap_req = 1'b1; step(); snap_req = 1'b0;
      out_if.out_ready = 1'b1; step(); step();
      out_if.out_ready = 1'b0;
      chk("pre_rst_channel", out_if.out_channel, 2);
      chk("pre_rst_valid", out_if.out_valid, 1);
      rst = 1'b1; step(); rst = 1'b0;
      chk("abort_valid", out_if.out_valid, 0);
      chk("abort_busy", snap_busy, 0);
      chk("abort_channel", out_if.out_channel, 0);
      chk("abort_time", out_if.out_time, 0);
      out_if.out_ready = 1'b1;
      repeat (6) step();
      chk("abort_beat_count", got_q.size(), 2);
      got_q.delete();
      snap_req = 1'b1; step(); idle_inputs();
      wait_idle();
      chk_got("post_rst_ch0", 0, 0, 0, 0);
      chk_got("post_rst_ch3", 3, 0, 0, 0);

      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/eth_stats_counter_bank.md
Name: eth_stats_counter_bank

Overview:
- Multi-channel successor to the single-port statistics adder. Accumulates bytes, good frames and bad frames for C_NUM_PORTS ethernet ports in one clock domain.
- Produces atomic, timestamped snapshots of all channels, streamed out one channel per beat over a valid/ready interface.
- Sits between the per-port frame counters (after any CDC) and the AXI register/FIFO logic.

Parameters:
- C_NUM_PORTS, 4, number of channels, 1..16.
- C_COUNTER_WIDTH, 64, width W of each bytes/good/bad accumulator, 16..64.
- C_LENGTH_WIDTH, 16, width of the per-frame byte count input.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  global accumulate enable.
- clear  in  C_NUM_PORTS  per-channel counter clear.
- current_time  in  64  reference timer, captured at snapshot.
- in_valid  in  C_NUM_PORTS  one completed frame reported on that channel this cycle.
- in_frame_length  in  C_NUM_PORTS*C_LENGTH_WIDTH  frame byte count; channel i at bits [i*L +: L].
- in_frame_good  in  C_NUM_PORTS  1 = good frame, 0 = bad frame.
- snap_req  in  1  snapshot request pulse/level.
- snap_busy  out  1  snapshot being streamed.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts beat.
- out_channel  out  max(1,$clog2(C_NUM_PORTS))  channel index of the beat.
- out_time  out  64  timestamp of the snapshot.
- out_bytes / out_good / out_bad  out  C_COUNTER_WIDTH each  snapshot values.
- out_last  out  1  beat is the last channel.

Behaviour:
- Reset (rst=1 at posedge): all accumulators, shadow registers and out_time = 0; FSM = IDLE; snap_busy=0, out_valid=0, out_last=0, out_channel=0. Reset mid-stream aborts the stream with no further beats.
- Accumulation, per channel i, every cycle:
  - clear[i]=1: all three counters of channel i go to 0. Clear has priority over a simultaneous in_valid[i].
  - Else, if enable=1 and in_valid[i]=1: bytes += zero-extended in_frame_length[i]. in_frame_good[i]=1 increments good by 1; otherwise bad increments by 1.
  - Update is visible on the counters 1 cycle after the input.
  - enable=0: in_valid is ignored and counters hold.
  - All channels update independently and in parallel; one frame per channel per cycle maximum.
- Arithmetic: modulo 2^W (wrap-around) unless the optional feature is compiled in.
- FSM, states IDLE, SEND:
  - IDLE: snap_req=1 at posedge copies all accumulators to shadow registers and current_time to out_time, then goes to SEND.
  - Captured values are the registered counter values at that edge, i.e. before any same-cycle in_valid/clear update.
  - Entering SEND: snap_busy=1, out_valid=1, out_channel=0, out_last = (C_NUM_PORTS==1). The first beat appears 1 cycle after snap_req.
  - SEND: out_* are driven from shadow[out_channel] and held stable while out_valid && !out_ready.
  - On out_valid && out_ready: if out_last, go to IDLE (out_valid=0, snap_busy=0 next cycle); else out_channel += 1, with out_last set when out_channel becomes C_NUM_PORTS-1.
  - snap_req during SEND is ignored, not queued.
  - Accumulation and clears continue during SEND and do not affect shadow values.
- Back-to-back: snap_req held high makes a new snapshot start on the first IDLE cycle, i.e. 1 idle cycle between streams.

Optional Feature:
- Macro ETH_STATS_SATURATE_EN.
- Defined: each counter saturates at 2^W-1. An increment that would overflow leaves the counter at all-ones; the bytes counter clamps to all-ones when the sum exceeds it. Clear still resets to 0.
- Not defined: modulo 2^W wrap-around.

Test Plan:
- rst then enable=1, channel 0 frames of 64 (good), 1518 (good), 60 (bad), then snap_req -> channel 0 beat bytes=1642, good=2, bad=1; other channels all 0; 4 beats, out_last only on channel 3; out_time = current_time at request edge.
- W=16, channel 1 bytes preset near 65530, add a 16-byte frame -> bytes=10 without macro; 65535 with ETH_STATS_SATURATE_EN.
- clear[2]=1 and in_valid[2]=1 (good, 100) in the same cycle -> channel 2 counters all 0 next cycle.
- snap_req in the same cycle as in_valid[0] (good, 64) on counters bytes=100, good=1 -> snapshot shows bytes=100, good=1; live counter becomes 164/2.
- out_ready low for 5 cycles on beat 1, frames arriving meanwhile -> out_* stable; snap_req pulses ignored; exactly C_NUM_PORTS beats delivered.
- rst asserted while streaming beat 2 -> out_valid=0, snap_busy=0 and counters 0 the next cycle; no further beats.
